// File: rtl/vending_controller_multi.sv
// Multi-tray vending sequencer: selection check, UPI payment handshake with
// timeout/fail/cancel, timed spring-motor phase and per-slot stock tracking.
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | waiting for a selection or a restock request
// S_CHECK    | validate index and stock, latch the price
// S_PAY_REQ  | one-cycle payment request pulse
// S_PAY_WAIT | waiting for pay_done / pay_fail / cancel / timeout
// S_VEND     | spring motor driven for MOTOR_CYCLES cycles
// S_DONE     | one-cycle dispense pulse
// S_ERR      | one-cycle error pulse, err_code already valid
module vending_controller_multi #(
   parameter int NUM_TRAYS         = 6,
   parameter int PRODUCTS_PER_TRAY = 8,
   parameter int STOCK_W           = 4,
   parameter int INIT_STOCK        = 5,
   parameter int PRICE_W           = 8,
   parameter int BASE_PRICE        = 10,
   parameter int TRAY_STEP         = 10,
   parameter int PAY_TIMEOUT       = 64,
   parameter int MOTOR_CYCLES      = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               sel_valid,
   input  logic [2:0]         tray_sel,
   input  logic [2:0]         product_sel,
   input  logic               cancel,
   input  logic               restock_valid,
   output logic               upi_pay_req,
   input  logic               upi_pay_done,
   input  logic               upi_pay_fail,
   output logic               spring_motor_en,
   output logic               dispense,
   output logic [PRICE_W-1:0] amount,
   output logic               busy,
   output logic               error,
   output logic [2:0]         err_code
);

   localparam int NSLOT  = NUM_TRAYS * PRODUCTS_PER_TRAY;
   localparam int SLOT_W = (NSLOT > 1) ? $clog2(NSLOT) : 1;
   localparam int TMO_W  = $clog2(PAY_TIMEOUT + 1);
   localparam int MOT_W  = $clog2(MOTOR_CYCLES + 1);

   localparam logic [2:0] E_NONE    = 3'd0;
   localparam logic [2:0] E_INVALID = 3'd1;
   localparam logic [2:0] E_STOCK   = 3'd2;
   localparam logic [2:0] E_PAYFAIL = 3'd3;
   localparam logic [2:0] E_TIMEOUT = 3'd4;
   localparam logic [2:0] E_CANCEL  = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_PAY_REQ, S_PAY_WAIT, S_VEND, S_DONE, S_ERR
   } state_t;

   state_t               r_state;
   state_t               w_nxt;

   logic [STOCK_W-1:0]   r_stock [NSLOT];
   logic [SLOT_W-1:0]    r_slot;
   logic [2:0]           r_tray;
   logic [2:0]           r_prod;
   logic                 r_sel_ok;
   logic [PRICE_W-1:0]   r_amount;
   logic [2:0]           r_err_code;
   logic [TMO_W-1:0]     r_tmo;
   logic [MOT_W-1:0]     r_mot;

   logic                 w_sel_ok;
   logic [SLOT_W-1:0]    w_sel_slot;
   logic [PRICE_W-1:0]   w_price;
   logic                 w_accept;
   logic                 w_restock;
   logic                 w_ld_amount;
   logic                 w_clr_amount;
   logic                 w_dec;
   logic                 w_set_err;
   logic [2:0]           w_err_val;

   assign w_sel_ok   = (32'(tray_sel) < NUM_TRAYS) && (32'(product_sel) < PRODUCTS_PER_TRAY);
   assign w_sel_slot = SLOT_W'(32'(tray_sel) * PRODUCTS_PER_TRAY + 32'(product_sel));
   // Price computed at full integer width, then truncated to the amount bus.
   assign w_price    = PRICE_W'(BASE_PRICE + TRAY_STEP * 32'(r_tray) + 32'(r_prod));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_nxt;
   end

   always_comb begin
      w_nxt        = r_state;
      w_accept     = 1'b0;
      w_restock    = 1'b0;
      w_ld_amount  = 1'b0;
      w_clr_amount = 1'b0;
      w_dec        = 1'b0;
      w_set_err    = 1'b0;
      w_err_val    = E_NONE;
      unique case (r_state)
         S_IDLE: begin
            if (restock_valid && w_sel_ok) begin
               w_restock = 1'b1;
            end else if (sel_valid) begin
               w_accept = 1'b1;
               w_nxt    = S_CHECK;
            end
         end
         S_CHECK: begin
            if (!r_sel_ok) begin
               w_set_err = 1'b1;
               w_err_val = E_INVALID;
               w_nxt     = S_ERR;
            end else if (r_stock[r_slot] == '0) begin
               w_set_err = 1'b1;
               w_err_val = E_STOCK;
               w_nxt     = S_ERR;
            end else begin
               w_ld_amount = 1'b1;
               w_nxt       = S_PAY_REQ;
            end
         end
         S_PAY_REQ: w_nxt = S_PAY_WAIT;
         S_PAY_WAIT: begin
            if (upi_pay_done) begin
               w_dec = 1'b1;
               w_nxt = S_VEND;
            end else if (upi_pay_fail) begin
               w_set_err = 1'b1;
               w_err_val = E_PAYFAIL;
               w_nxt     = S_ERR;
            end else if (cancel) begin
               w_set_err = 1'b1;
               w_err_val = E_CANCEL;
               w_nxt     = S_ERR;
            end else if (r_tmo == TMO_W'(PAY_TIMEOUT - 1)) begin
               w_set_err = 1'b1;
               w_err_val = E_TIMEOUT;
               w_nxt     = S_ERR;
            end
         end
         S_VEND: begin
            if (r_mot == MOT_W'(MOTOR_CYCLES - 1)) w_nxt = S_DONE;
         end
         S_DONE: begin
            w_clr_amount = 1'b1;
            w_nxt        = S_IDLE;
         end
         S_ERR:   w_nxt = S_IDLE;
         default: w_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_slot     <= '0;
         r_tray     <= '0;
         r_prod     <= '0;
         r_sel_ok   <= 1'b0;
         r_amount   <= '0;
         r_err_code <= E_NONE;
         r_tmo      <= '0;
         r_mot      <= '0;
         for (int i = 0; i < NSLOT; i++) r_stock[i] <= STOCK_W'(INIT_STOCK);
      end else begin
         if (w_accept) begin
            r_tray     <= tray_sel;
            r_prod     <= product_sel;
            r_sel_ok   <= w_sel_ok;
            // Invalid selections park on slot 0 so the stock lookup stays in range.
            r_slot     <= w_sel_ok ? w_sel_slot : '0;
            r_err_code <= E_NONE;
         end
         if (w_set_err) r_err_code <= w_err_val;
         if (w_ld_amount)                   r_amount <= w_price;
         else if (w_clr_amount || w_set_err) r_amount <= '0;
         if (w_restock) r_stock[w_sel_slot] <= STOCK_W'(INIT_STOCK);
         if (w_dec)     r_stock[r_slot]     <= r_stock[r_slot] - STOCK_W'(1);
         r_tmo <= (r_state == S_PAY_WAIT) ? r_tmo + TMO_W'(1) : '0;
         r_mot <= (r_state == S_VEND)     ? r_mot + MOT_W'(1) : '0;
      end
   end

   assign upi_pay_req     = (r_state == S_PAY_REQ);
   assign spring_motor_en = (r_state == S_VEND);
   assign dispense        = (r_state == S_DONE);
   assign error           = (r_state == S_ERR);
   assign busy            = (r_state != S_IDLE);
   assign amount          = r_amount;
   assign err_code        = r_err_code;

endmodule
